// File: rtl/riscv_core_pkg.sv
// Shared definitions for the riscv_core pipeline: opcodes, function codes,
// ALU operations and immediate formats.
package riscv_core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB / SRA; the caller must only raise it where bit 30 is a function bit
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_core_alu.sv
// Combinational 32-bit integer ALU for the EX stage.
module riscv_core_alu
  import riscv_core_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:   res_o = a_i + b_i;
      ALU_SUB:   res_o = a_i - b_i;
      ALU_SLL:   res_o = a_i << shamt;
      ALU_SLT:   res_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  res_o = {31'b0, a_i < b_i};
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_SRL:   res_o = a_i >> shamt;
      ALU_SRA:   res_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:    res_o = a_i | b_i;
      ALU_AND:   res_o = a_i & b_i;
      ALU_PASSB: res_o = b_i;
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_core_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
module riscv_core_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] MEM [0:31];

  assign rdata1_o = MEM[raddr1_i];
  assign rdata2_o = MEM[raddr2_i];

  // MEM[0] is never written, so x0 reads zero without a read-side mux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) MEM[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      MEM[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/riscv_core.sv
// RV32I core, 3-stage pipeline (IF / EX / WB) between synchronous instruction
// and data memories with 1-cycle read latency.
module riscv_core
  import riscv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] IM_addr_o,
  input  logic [31:0] IM_data_i,
  output logic        DM_EN_o,
  output logic        DM_WEN_o,
  output logic [31:0] DM_addr_o,
  output logic [31:0] DM_data_o,
  input  logic [31:0] DM_data_i
);

  logic [31:0] pc_q, pc_d, pc_ex_q, pc_ex_d, wb_data_q, wb_data_d;
  logic        ex_valid_q, ex_valid_d, wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d, wb_is_load_q, wb_is_load_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic [31:0] instr, imm, rs1_rf, rs2_rf, rs1_val, rs2_val, wb_val;
  logic [31:0] alu_a, alu_b, alu_res, target, pc_ex_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  alu_op_e     alu_op;
  imm_type_e   imm_type;
  logic        use_pc_a, use_imm_b, rd_we, is_load, is_store;
  logic        is_branch, is_jal, is_jalr, br_cond, redirect;

  assign instr  = IM_data_i;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  riscv_core_regfile u_REGFILE (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_rf),
    .rdata2_o (rs2_rf),
    .we_i     (wb_valid_q && wb_we_q),
    .waddr_i  (wb_rd_q),
    .wdata_i  (wb_val)
  );

  // A load's WB value is the memory data arriving this cycle, which makes load-use stall-free
  assign wb_val  = wb_is_load_q ? DM_data_i : wb_data_q;
  assign rs1_val = (wb_valid_q && wb_we_q && wb_rd_q != 5'd0 && wb_rd_q == rs1) ? wb_val : rs1_rf;
  assign rs2_val = (wb_valid_q && wb_we_q && wb_rd_q != 5'd0 && wb_rd_q == rs2) ? wb_val : rs2_rf;

  always_comb begin
    alu_op    = ALU_ADD;
    imm_type  = IMM_I;
    use_pc_a  = 1'b0;
    use_imm_b = 1'b0;
    rd_we     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    if (ex_valid_q) begin
      case (opcode)
        OPC_LUI:    begin imm_type = IMM_U; use_imm_b = 1'b1; alu_op = ALU_PASSB; rd_we = 1'b1; end
        OPC_AUIPC:  begin imm_type = IMM_U; use_pc_a = 1'b1; use_imm_b = 1'b1; rd_we = 1'b1; end
        OPC_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; rd_we = 1'b1; end
        OPC_JALR:   begin imm_type = IMM_I; is_jalr = 1'b1; rd_we = 1'b1; end
        OPC_BRANCH: begin imm_type = IMM_B; is_branch = 1'b1; end
        OPC_LOAD:   begin imm_type = IMM_I; use_imm_b = 1'b1; is_load = 1'b1; rd_we = 1'b1; end
        OPC_STORE:  begin imm_type = IMM_S; use_imm_b = 1'b1; is_store = 1'b1; end
        OPC_OPIMM:  begin
          use_imm_b = 1'b1;
          rd_we     = 1'b1;
          alu_op    = alu_from_f3(funct3, (funct3 == F3_SR) && instr[30]);
        end
        OPC_OP:     begin rd_we = 1'b1; alu_op = alu_from_f3(funct3, instr[30]); end
        default:    ;
      endcase
    end
  end

  assign imm   = imm_gen(instr, imm_type);
  assign alu_a = use_pc_a ? pc_ex_q : rs1_val;
  assign alu_b = use_imm_b ? imm : rs2_val;

  riscv_core_alu u_alu (
    .op_i  (alu_op),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .res_o (alu_res)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (rs1_val == rs2_val);
      F3_BNE:  br_cond = (rs1_val != rs2_val);
      F3_BLT:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_cond = (rs1_val < rs2_val);
      F3_BGEU: br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_ex_plus4 = pc_ex_q + 32'd4;
  assign redirect    = is_jal || is_jalr || (is_branch && br_cond);
  assign target      = is_jalr ? ((rs1_val + imm) & ~32'd1) : (pc_ex_q + imm);

  assign IM_addr_o = pc_q;
  assign DM_EN_o   = ~(is_load || is_store);
  assign DM_WEN_o  = ~is_store;
  assign DM_addr_o = (is_load || is_store) ? alu_res : 32'd0;
  assign DM_data_o = is_store ? rs2_val : 32'd0;

  // On a redirect the word fetched from pc_ex+4 arrives next cycle and is squashed
  always_comb begin
    pc_d         = redirect ? target : pc_q + 32'd4;
    pc_ex_d      = pc_q;
    ex_valid_d   = ~redirect;
    wb_valid_d   = ex_valid_q;
    wb_we_d      = rd_we;
    wb_rd_d      = rd;
    wb_is_load_d = is_load;
    wb_data_d    = (is_jal || is_jalr) ? pc_ex_plus4 : alu_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pc_ex_q      <= RESET_PC;
      ex_valid_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_is_load_q <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      pc_ex_q      <= pc_ex_d;
      ex_valid_q   <= ex_valid_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_is_load_q <= wb_is_load_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
// Directed-program bench for riscv_core: small hand-assembled programs,
// register file and data memory compared against hand-computed golden values.
module tb_riscv_core;
  import riscv_core_pkg::*;

  localparam int RUN_CYCLES = 10000;

  logic        clk, rst;
  logic [31:0] IM_addr_o, IM_data_i, DM_addr_o, DM_data_o, DM_data_i;
  logic        DM_EN_o, DM_WEN_o;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [31:0] gold [1:31];
  int n_tests, n_fail;

  riscv_core #(.RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .IM_addr_o (IM_addr_o),
    .IM_data_i (IM_data_i),
    .DM_EN_o   (DM_EN_o),
    .DM_WEN_o  (DM_WEN_o),
    .DM_addr_o (DM_addr_o),
    .DM_data_o (DM_data_o),
    .DM_data_i (DM_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) IM_data_i <= imem[IM_addr_o[9:2]];

  always @(posedge clk) begin
    if (!DM_EN_o) begin
      if (!DM_WEN_o) dmem[DM_addr_o[9:2]] <= DM_data_o;
      else           DM_data_i <= dmem[DM_addr_o[9:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction
  function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] u_t(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction
  function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      imem[i] = i_t(0, 0, 0, 0, OPC_OPIMM);
      dmem[i] = '0;
    end
    for (int i = 1; i < 32; i++) gold[i] = '0;
  endtask

  task automatic load_prog1();
    clear_mems();
    imem[0]  = i_t(5, 0, F3_ADD, 1, OPC_OPIMM);
    imem[1]  = i_t(-7, 1, F3_ADD, 2, OPC_OPIMM);
    imem[2]  = u_t(32'h12345, 3, OPC_LUI);
    imem[3]  = i_t(32'h678, 3, F3_ADD, 3, OPC_OPIMM);
    imem[4]  = s_t(8, 3, 0, 3'b010);
    imem[5]  = i_t(8, 0, 3'b010, 4, OPC_LOAD);
    imem[6]  = r_t(0, 4, 4, F3_ADD, 5);
    imem[7]  = b_t(8, 1, 0, F3_BNE);
    imem[8]  = i_t(1, 0, F3_ADD, 6, OPC_OPIMM);
    imem[9]  = j_t(12, 7);
    imem[10] = i_t(1, 9, F3_ADD, 9, OPC_OPIMM);
    imem[11] = j_t(12, 0);
    imem[12] = i_t(0, 7, 3'b000, 8, OPC_JALR);
    imem[13] = i_t(1, 0, F3_ADD, 10, OPC_OPIMM);
    imem[14] = i_t(-1, 0, F3_ADD, 11, OPC_OPIMM);
    imem[15] = i_t(1, 0, F3_ADD, 12, OPC_OPIMM);
    imem[16] = r_t(0, 12, 11, F3_SLT, 13);
    imem[17] = r_t(0, 12, 11, F3_SLTU, 14);
    imem[18] = i_t(32'h404, 11, F3_SR, 15, OPC_OPIMM);
    imem[19] = i_t(5, 0, F3_ADD, 0, OPC_OPIMM);
    imem[20] = r_t(0, 12, 0, F3_ADD, 16);
    imem[21] = b_t(8, 12, 11, F3_BLT);
    imem[22] = i_t(1, 0, F3_ADD, 17, OPC_OPIMM);
    imem[23] = b_t(8, 12, 11, F3_BLTU);
    imem[24] = i_t(7, 0, F3_ADD, 18, OPC_OPIMM);
    imem[25] = r_t(7'h20, 11, 12, F3_ADD, 19);
    imem[26] = r_t(0, 1, 12, F3_SLL, 20);
    imem[27] = r_t(0, 1, 11, F3_SR, 21);
    imem[28] = r_t(0, 11, 3, F3_XOR, 22);
    imem[29] = u_t(1, 23, OPC_AUIPC);
    imem[30] = j_t(0, 0);
    gold[1] = 32'd5;         gold[2] = 32'hFFFF_FFFE;  gold[3] = 32'h1234_5678;
    gold[4] = 32'h1234_5678; gold[5] = 32'h2468_ACF0;  gold[7] = 32'h28;
    gold[8] = 32'h34;        gold[9] = 32'd1;          gold[11] = 32'hFFFF_FFFF;
    gold[12] = 32'd1;        gold[13] = 32'd1;         gold[15] = 32'hFFFF_FFFF;
    gold[16] = 32'd1;        gold[18] = 32'd7;         gold[19] = 32'd2;
    gold[20] = 32'h20;       gold[21] = 32'h07FF_FFFF; gold[22] = 32'hEDCB_A987;
    gold[23] = 32'h1074;
  endtask

  task automatic load_prog2();
    clear_mems();
    imem[0]  = i_t(-16, 0, F3_ADD, 1, OPC_OPIMM);
    imem[1]  = i_t(32'hF, 1, F3_OR, 2, OPC_OPIMM);
    imem[2]  = i_t(32'h7F, 1, F3_AND, 3, OPC_OPIMM);
    imem[3]  = i_t(0, 1, F3_SLT, 4, OPC_OPIMM);
    imem[4]  = i_t(1, 1, F3_SLTU, 5, OPC_OPIMM);
    imem[5]  = b_t(8, 2, 2, F3_BEQ);
    imem[6]  = i_t(1, 0, F3_ADD, 6, OPC_OPIMM);
    imem[7]  = b_t(8, 0, 1, F3_BGE);
    imem[8]  = i_t(3, 0, F3_ADD, 7, OPC_OPIMM);
    imem[9]  = b_t(8, 0, 1, F3_BGEU);
    imem[10] = i_t(1, 0, F3_ADD, 8, OPC_OPIMM);
    imem[11] = 32'hFFFF_FFFF;
    imem[12] = s_t(4, 3, 0, 3'b001);
    imem[13] = i_t(4, 0, 3'b000, 9, OPC_LOAD);
    imem[14] = r_t(0, 9, 9, F3_ADD, 11);
    imem[15] = i_t(28, 1, F3_SR, 10, OPC_OPIMM);
    imem[16] = r_t(7'h20, 7, 1, F3_SR, 12);
    imem[17] = r_t(0, 3, 2, F3_AND, 13);
    imem[18] = i_t(30, 7, F3_SLL, 14, OPC_OPIMM);
    imem[19] = r_t(0, 14, 14, F3_ADD, 15);
    imem[20] = j_t(0, 0);
    gold[1] = 32'hFFFF_FFF0; gold[2] = 32'hFFFF_FFFF;  gold[3] = 32'h70;
    gold[4] = 32'd1;         gold[7] = 32'd3;          gold[9] = 32'h70;
    gold[10] = 32'hF;        gold[11] = 32'hE0;        gold[12] = 32'hFFFF_FFFE;
    gold[13] = 32'h70;       gold[14] = 32'hC000_0000; gold[15] = 32'h8000_0000;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 1; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.u_REGFILE.MEM[i], gold[i]);
  endtask

  task automatic release_and_run();
    @(negedge clk);
    rst = 1'b0;
    check("first_fetch_pc", IM_addr_o, 32'h0);
    @(posedge clk); #1;
    check("second_fetch_pc", IM_addr_o, 32'h4);
    repeat (RUN_CYCLES) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    load_prog1();
    #12;
    check("rst_im_addr", IM_addr_o, 32'h0);
    check("rst_dm_en", {31'b0, DM_EN_o}, 32'd1);
    check("rst_dm_wen", {31'b0, DM_WEN_o}, 32'd1);
    check("rst_dm_addr", DM_addr_o, 32'h0);
    check("rst_dm_data", DM_data_o, 32'h0);

    release_and_run();
    check_regs("p1");
    check("p1_dmem2", dmem[2], 32'h1234_5678);

    rst = 1'b1;
    load_prog2();
    #1;
    check("rst2_x1_clear", dut.u_REGFILE.MEM[1], 32'h0);
    release_and_run();
    check_regs("p2");
    check("p2_dmem1", dmem[1], 32'h70);

    rst = 1'b1;
    load_prog1();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    check("mid_pre_x1", dut.u_REGFILE.MEM[1], 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_im_addr", IM_addr_o, 32'h0);
    check("mid_rst_dm_en", {31'b0, DM_EN_o}, 32'd1);
    check("mid_rst_x1", dut.u_REGFILE.MEM[1], 32'h0);
    check("mid_rst_x3", dut.u_REGFILE.MEM[3], 32'h0);
    release_and_run();
    check_regs("p1r");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
